// File: rtl/flux_rf_pkg.sv
// flux_rf_pkg: shared sizes and the collector state encoding for the RF operand collector.
package flux_rf_pkg;
  localparam int NUM_THREADS = 32;
  localparam int NUM_REGS    = 32;
  localparam int DATA_WIDTH  = 128;
  localparam int REG_ADDR_W  = 5;
  localparam int TID_W       = $clog2(NUM_THREADS);
  localparam int TAG_W       = 16;
  typedef enum logic [1:0] {IDLE, RD_AB, RD_C, HOLD} collector_state_e;
endpackage

// File: rtl/rf_bypass_mux.sv
// rf_bypass_mux: per-operand write-port snoop; with RF_BYPASS_EN a same-cycle write hit
// (same tid/addr, addr != R0) replaces the RF read data, otherwise a plain passthrough.
module rf_bypass_mux
  import flux_rf_pkg::*;
(
  input  logic                  wb_en_i,
  input  logic [TID_W-1:0]      wb_tid_i,
  input  logic [REG_ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  input  logic [TID_W-1:0]      tid_i,
  input  logic [REG_ADDR_W-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic [DATA_WIDTH-1:0] data_o
);
`ifdef RF_BYPASS_EN
  assign data_o = (wb_en_i && wb_tid_i == tid_i && wb_addr_i == addr_i && addr_i != '0)
                  ? wb_data_i : rd_data_i;
`else
  logic unused_snoop;
  assign unused_snoop = ^{wb_en_i, wb_tid_i, wb_addr_i, wb_data_i, tid_i, addr_i};
  assign data_o = rd_data_i;
`endif
endmodule

// File: rtl/rf_operand_collector.sv
// rf_operand_collector: sequences up to three source reads over two RF read ports and hands
// the collected operands to execute; RF_BYPASS_EN enables write-port forwarding at capture.
module rf_operand_collector
  import flux_rf_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  logic [TID_W-1:0]      issue_tid_i,
  input  logic [REG_ADDR_W-1:0] issue_src_a_i,
  input  logic [REG_ADDR_W-1:0] issue_src_b_i,
  input  logic [REG_ADDR_W-1:0] issue_src_c_i,
  input  logic [1:0]            issue_num_src_i,
  input  logic [TAG_W-1:0]      issue_tag_i,
  output logic [TID_W-1:0]      rf_rd_tid_a_o,
  output logic [TID_W-1:0]      rf_rd_tid_b_o,
  output logic [REG_ADDR_W-1:0] rf_rd_addr_a_o,
  output logic [REG_ADDR_W-1:0] rf_rd_addr_b_o,
  input  logic [DATA_WIDTH-1:0] rf_rd_data_a_i,
  input  logic [DATA_WIDTH-1:0] rf_rd_data_b_i,
  input  logic                  wb_en_i,
  input  logic [TID_W-1:0]      wb_tid_i,
  input  logic [REG_ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [TID_W-1:0]      out_tid_o,
  output logic [TAG_W-1:0]      out_tag_o,
  output logic [DATA_WIDTH-1:0] out_op_a_o,
  output logic [DATA_WIDTH-1:0] out_op_b_o,
  output logic [DATA_WIDTH-1:0] out_op_c_o,
  output logic [31:0]           stall_cnt_o
);
  collector_state_e      state_q;
  logic [TID_W-1:0]      tid_q;
  logic [REG_ADDR_W-1:0] src_a_q, src_b_q, src_c_q;
  logic [1:0]            num_q;
  logic [TAG_W-1:0]      tag_q;
  logic [DATA_WIDTH-1:0] op_a_q, op_b_q, op_c_q, cap_a_d, cap_b_d;
  logic                  out_valid_q;
  logic [31:0]           stall_q;
  logic                  accept, rd_ab, rd_c, use_a, use_b;
  assign rd_ab         = state_q == RD_AB;
  assign rd_c          = state_q == RD_C;
  assign issue_ready_o = state_q == IDLE || (state_q == HOLD && out_ready_i);
  assign accept        = issue_valid_i && issue_ready_o;
  // Ports serving a masked source stay at tid 0 / R0 so they never read or bypass.
  assign use_a          = rd_ab && num_q != 2'd0;
  assign use_b          = rd_ab && num_q[1];
  assign rf_rd_tid_a_o  = (use_a || rd_c) ? tid_q : '0;
  assign rf_rd_addr_a_o = use_a ? src_a_q : rd_c ? src_c_q : '0;
  assign rf_rd_tid_b_o  = use_b ? tid_q : '0;
  assign rf_rd_addr_b_o = use_b ? src_b_q : '0;
  rf_bypass_mux u_byp_a (
    .wb_en_i(wb_en_i), .wb_tid_i(wb_tid_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .tid_i(rf_rd_tid_a_o), .addr_i(rf_rd_addr_a_o), .rd_data_i(rf_rd_data_a_i), .data_o(cap_a_d)
  );
  rf_bypass_mux u_byp_b (
    .wb_en_i(wb_en_i), .wb_tid_i(wb_tid_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .tid_i(rf_rd_tid_b_o), .addr_i(rf_rd_addr_b_o), .rd_data_i(rf_rd_data_b_i), .data_o(cap_b_d)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      tid_q       <= '0;
      src_a_q     <= '0;
      src_b_q     <= '0;
      src_c_q     <= '0;
      num_q       <= '0;
      tag_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_c_q      <= '0;
      out_valid_q <= 1'b0;
      stall_q     <= '0;
    end else begin
      if (accept) begin
        tid_q   <= issue_tid_i;
        src_a_q <= issue_src_a_i;
        src_b_q <= issue_src_b_i;
        src_c_q <= issue_src_c_i;
        num_q   <= issue_num_src_i;
        tag_q   <= issue_tag_i;
      end
      case (state_q)
        IDLE: if (issue_valid_i) state_q <= RD_AB;
        RD_AB: begin
          op_a_q      <= use_a ? cap_a_d : '0;
          op_b_q      <= use_b ? cap_b_d : '0;
          op_c_q      <= '0;
          state_q     <= (num_q == 2'd3) ? RD_C : HOLD;
          out_valid_q <= num_q != 2'd3;
        end
        RD_C: begin
          op_c_q      <= cap_a_d;
          state_q     <= HOLD;
          out_valid_q <= 1'b1;
        end
        HOLD:
          if (out_ready_i) begin
            state_q     <= issue_valid_i ? RD_AB : IDLE;
            out_valid_q <= 1'b0;
          end else if (stall_q != '1) stall_q <= stall_q + 32'd1;
        default: state_q <= IDLE;
      endcase
    end
  assign out_valid_o = out_valid_q;
  assign out_tid_o   = tid_q;
  assign out_tag_o   = tag_q;
  assign out_op_a_o  = op_a_q;
  assign out_op_b_o  = op_b_q;
  assign out_op_c_o  = op_c_q;
  assign stall_cnt_o = stall_q;
endmodule

// File: tb/tb_rf_operand_collector.sv
// tb_rf_operand_collector: directed scenarios plus a randomized issue/drain stream scored
// against an in-order queue of operands predicted from a behavioural register file.
module tb_rf_operand_collector;
  logic         clk = 1'b0, rst_n = 1'b0;
  logic         issue_valid = 1'b0, issue_ready;
  logic [4:0]   issue_tid = '0, issue_src_a = '0, issue_src_b = '0, issue_src_c = '0;
  logic [1:0]   issue_num_src = '0;
  logic [15:0]  issue_tag = '0;
  logic [4:0]   rd_tid_a, rd_tid_b, rd_addr_a, rd_addr_b;
  logic [127:0] rd_data_a, rd_data_b;
  logic         wb_en = 1'b0;
  logic [4:0]   wb_tid = '0, wb_addr = '0;
  logic [127:0] wb_data = '0;
  logic         out_valid, out_ready = 1'b0;
  logic [4:0]   out_tid;
  logic [15:0]  out_tag;
  logic [127:0] out_op_a, out_op_b, out_op_c;
  logic [31:0]  stall_cnt;
  logic [127:0] rf [32][32];
  int           vec = 0, mis = 0;
  logic [15:0]  tag_n = 16'h1000;
  localparam logic [127:0] X11 = {16{8'h11}}, X22 = {16{8'h22}}, XAB = {16{8'hAB}}, XCD = {16{8'hCD}};
  typedef struct {
    logic [4:0]   tid;
    logic [15:0]  tag;
    logic [127:0] a, b, c;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  assign rd_data_a = (rd_addr_a == '0) ? '0 : rf[rd_tid_a][rd_addr_a];
  assign rd_data_b = (rd_addr_b == '0) ? '0 : rf[rd_tid_b][rd_addr_b];

  rf_operand_collector dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready), .issue_tid_i(issue_tid),
    .issue_src_a_i(issue_src_a), .issue_src_b_i(issue_src_b), .issue_src_c_i(issue_src_c),
    .issue_num_src_i(issue_num_src), .issue_tag_i(issue_tag),
    .rf_rd_tid_a_o(rd_tid_a), .rf_rd_tid_b_o(rd_tid_b),
    .rf_rd_addr_a_o(rd_addr_a), .rf_rd_addr_b_o(rd_addr_b),
    .rf_rd_data_a_i(rd_data_a), .rf_rd_data_b_i(rd_data_b),
    .wb_en_i(wb_en), .wb_tid_i(wb_tid), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_tid_o(out_tid), .out_tag_o(out_tag),
    .out_op_a_o(out_op_a), .out_op_b_o(out_op_b), .out_op_c_o(out_op_c), .stall_cnt_o(stall_cnt)
  );

  task automatic chk(input string nm, input logic [127:0] obs, input logic [127:0] exp);
    vec++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s: observed %h expected %h", nm, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [4:0] t, a, b, c, input logic [1:0] n, input logic [15:0] tg);
    issue_valid = 1'b1; issue_tid = t; issue_src_a = a; issue_src_b = b; issue_src_c = c;
    issue_num_src = n; issue_tag = tg;
  endtask

  task automatic wr(input logic en, input logic [4:0] t, a, input logic [127:0] d);
    wb_en = en; wb_tid = t; wb_addr = a; wb_data = d;
  endtask

  function automatic logic [127:0] rdm(input logic [4:0] t, input logic [4:0] a);
    return (a == '0) ? '0 : rf[t][a];
  endfunction

  // Scoreboard step for the random stream: retire on output handshake, predict on issue handshake.
  task automatic step;
    exp_t e;
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("rnd_spurious_out", 128'(out_valid), '0);
      else begin
        e = q.pop_front();
        chk("rnd_tag", 128'(out_tag), 128'(e.tag));
        chk("rnd_tid", 128'(out_tid), 128'(e.tid));
        chk("rnd_op_a", out_op_a, e.a);
        chk("rnd_op_b", out_op_b, e.b);
        chk("rnd_op_c", out_op_c, e.c);
      end
    end
    if (issue_valid && issue_ready) begin
      e.tid = issue_tid;
      e.tag = issue_tag;
      e.a = (issue_num_src >= 2'd1) ? rdm(issue_tid, issue_src_a) : '0;
      e.b = (issue_num_src >= 2'd2) ? rdm(issue_tid, issue_src_b) : '0;
      e.c = (issue_num_src == 2'd3) ? rdm(issue_tid, issue_src_c) : '0;
      q.push_back(e);
      tag_n++;
    end
  endtask

  initial begin
    for (int t = 0; t < 32; t++)
      for (int r = 0; r < 32; r++) rf[t][r] = {$urandom, $urandom, $urandom, $urandom};
    rf[3][5] = X11;
    rf[3][6] = X22;
    repeat (2) @(negedge clk);
    chk("rst_issue_ready", 128'(issue_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), '0);
    chk("rst_stall", 128'(stall_cnt), '0);
    chk("rst_op_a", out_op_a, '0);
    chk("rst_rd_addr_a", 128'(rd_addr_a), '0);
    rst_n = 1'b1;
    // Two-source read, out_ready high
    out_ready = 1'b1;
    issue(5'd3, 5'd5, 5'd6, 5'd0, 2'd2, 16'h0101);
    #1 chk("t1_issue_ready", 128'(issue_ready), 128'(1));
    tick;
    issue_valid = 1'b0;
    chk("t1_rdab_valid", 128'(out_valid), '0);
    chk("t1_rd_addr_a", 128'(rd_addr_a), 128'(5));
    chk("t1_rd_addr_b", 128'(rd_addr_b), 128'(6));
    chk("t1_rd_tid_a", 128'(rd_tid_a), 128'(3));
    tick;
    chk("t1_out_valid", 128'(out_valid), 128'(1));
    chk("t1_op_a", out_op_a, X11);
    chk("t1_op_b", out_op_b, X22);
    chk("t1_op_c", out_op_c, '0);
    chk("t1_tag", 128'(out_tag), 128'(16'h0101));
    chk("t1_tid", 128'(out_tid), 128'(3));
    tick;
    chk("t1_idle_valid", 128'(out_valid), '0);
    chk("t1_idle_ready", 128'(issue_ready), 128'(1));
    // Three-source read goes through RD_C, then stalls 10 cycles
    issue(5'd3, 5'd1, 5'd2, 5'd7, 2'd3, 16'h0202);
    tick;
    issue_valid = 1'b0;
    chk("t2_rdab_valid", 128'(out_valid), '0);
    tick;
    chk("t2_rdc_addr_a", 128'(rd_addr_a), 128'(7));
    chk("t2_rdc_addr_b", 128'(rd_addr_b), '0);
    chk("t2_rdc_valid", 128'(out_valid), '0);
    out_ready = 1'b0;
    tick;
    chk("t2_out_valid", 128'(out_valid), 128'(1));
    chk("t2_op_a", out_op_a, rf[3][1]);
    chk("t2_op_b", out_op_b, rf[3][2]);
    chk("t2_op_c", out_op_c, rf[3][7]);
    issue(5'd3, 5'd5, 5'd6, 5'd0, 2'd1, 16'h0303);
    for (int i = 0; i < 10; i++) begin
      #1 chk("t3_issue_ready_low", 128'(issue_ready), '0);
      chk("t3_hold_op_c", out_op_c, rf[3][7]);
      tick;
    end
    chk("t3_stall_cnt", 128'(stall_cnt), 128'(10));
    chk("t3_hold_valid", 128'(out_valid), 128'(1));
    chk("t3_hold_tag", 128'(out_tag), 128'(16'h0202));
    out_ready = 1'b1;
    #1 chk("t3_b2b_ready", 128'(issue_ready), 128'(1));
    tick;
    issue_valid = 1'b0;
    chk("t3_b2b_rdab_valid", 128'(out_valid), '0);
    chk("t3_b2b_rd_addr_a", 128'(rd_addr_a), 128'(5));
    chk("t3_b2b_rd_addr_b", 128'(rd_addr_b), '0);
    tick;
    chk("t3_b2b_valid", 128'(out_valid), 128'(1));
    chk("t3_b2b_op_a", out_op_a, X11);
    chk("t3_b2b_op_b_masked", out_op_b, '0);
    chk("t3_b2b_tag", 128'(out_tag), 128'(16'h0303));
    chk("t3_stall_kept", 128'(stall_cnt), 128'(10));
    tick;
    // Zero sources still spends one read cycle
    issue(5'd3, 5'd5, 5'd6, 5'd7, 2'd0, 16'h0404);
    tick;
    issue_valid = 1'b0;
    chk("t0_rd_addr_a", 128'(rd_addr_a), '0);
    tick;
    chk("t0_valid", 128'(out_valid), 128'(1));
    chk("t0_op_a", out_op_a, '0);
    chk("t0_tag", 128'(out_tag), 128'(16'h0404));
    tick;
    // Same-cycle write at the capture edge
    issue(5'd3, 5'd5, 5'd6, 5'd0, 2'd2, 16'h0505);
    tick;
    issue_valid = 1'b0;
    out_ready = 1'b0;
    wr(1'b1, 5'd3, 5'd5, XAB);
    tick;
    rf[3][5] = XAB;
`ifdef RF_BYPASS_EN
    chk("t4_bypass_op_a", out_op_a, XAB);
`else
    chk("t4_nobypass_op_a", out_op_a, X11);
`endif
    chk("t4_op_b", out_op_b, X22);
    wr(1'b1, 5'd3, 5'd6, XCD);
    tick;
    rf[3][6] = XCD;
    wr(1'b0, 5'd0, 5'd0, '0);
    chk("t4_held_op_b", out_op_b, X22);
    out_ready = 1'b1;
    tick;
    issue(5'd3, 5'd0, 5'd6, 5'd0, 2'd2, 16'h0606);
    tick;
    issue_valid = 1'b0;
    wr(1'b1, 5'd3, 5'd0, '1);
    tick;
    wr(1'b0, 5'd0, 5'd0, '0);
    chk("t4_r0_no_bypass", out_op_a, '0);
    chk("t4_write_landed", out_op_b, XCD);
    tick;
    // Asynchronous reset in RD_C
    issue(5'd3, 5'd1, 5'd2, 5'd7, 2'd3, 16'h0707);
    tick;
    issue_valid = 1'b0;
    tick;
    chk("t5_in_rdc", 128'(rd_addr_a), 128'(7));
    #2 rst_n = 1'b0;
    #1;
    chk("t5_valid", 128'(out_valid), '0);
    chk("t5_op_a", out_op_a, '0);
    chk("t5_op_b", out_op_b, '0);
    chk("t5_op_c", out_op_c, '0);
    chk("t5_issue_ready", 128'(issue_ready), 128'(1));
    chk("t5_stall", 128'(stall_cnt), '0);
    chk("t5_rd_addr_a", 128'(rd_addr_a), '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    // Random issue/out_ready stream
    for (int i = 0; i < 400; i++) begin
      issue_valid   = 1'($urandom_range(0, 1));
      issue_tid     = 5'($urandom_range(0, 31));
      issue_src_a   = 5'($urandom_range(0, 31));
      issue_src_b   = 5'($urandom_range(0, 31));
      issue_src_c   = 5'($urandom_range(0, 31));
      issue_num_src = 2'($urandom_range(0, 3));
      issue_tag     = tag_n;
      out_ready     = $urandom_range(0, 3) != 0;
      #1 step;
      tick;
    end
    issue_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 12 && q.size() != 0; i++) begin
      #1 step;
      tick;
    end
    chk("rnd_drained", 128'(q.size()), '0);
    chk("rnd_final_valid", 128'(out_valid), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
